inst_prefetch_queue: RTL
========================

Name: inst_prefetch_queue

Overview:
Instruction prefetch buffer between the ICACHE and the IF-stage realigner. It runs ahead of the fetch stream, issuing sequential word reads to the ICACHE and holding up to DEPTH words. It presents an ICACHE-compatible interface to the realigner, so IF wiring is unchanged apart from re-pointing the realigner's ICACHE ports here. A redirect (taken branch, jal/jalr, predicted-taken branch) flushes the queue and restarts prefetch at the new word address.

Parameters:
DEPTH, 4, queue entries (power of two, >=2); each entry holds a 30-bit word address and 32-bit data

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect  in  1  flush queue and restart prefetch at redirect_addr
redirect_addr  in  30  word address of the new fetch stream
cons_ren  in  1  realigner read request
cons_addr  in  30  realigner word address
cons_rdata  out  32  word returned to realigner
cons_stall  out  1  high: cons_rdata not valid this cycle
ICACHE_ren  out  1  cache read request
ICACHE_wen  out  1  constant 0
ICACHE_addr  out  30  cache word address
ICACHE_wdata  out  32  constant 0
ICACHE_rdata  in  32  cache read data
ICACHE_stall  in  1  cache busy; data valid when ren=1 and stall=0

Behaviour:
- Reset (async, rst_n=0): queue empty, state IDLE, ICACHE_ren=0, ICACHE_addr=0, fetch_addr=0, no pending redirect.
- Queue: circular FIFO, head/tail pointers, count width clog2(DEPTH)+1. Entry0 = head, entry1 = head+1.
- Consumer lookup (combinational):
  - hit0: cons_ren, count>=1, entry0.addr==cons_addr -> cons_rdata=entry0.data, cons_stall=0, no pop (re-reads of same word allowed for compressed/misaligned fetch).
  - hit1: cons_ren, count>=2, entry1.addr==cons_addr -> cons_rdata=entry1.data, cons_stall=0, head popped at clock edge.
  - otherwise cons_stall=cons_ren; cons_rdata=entry0.data (don't care).
  - cons_ren=1 with no hit and no outstanding match (queue non-empty and cons_addr not entry0/entry1, or queue empty and fetch_addr!=cons_addr): implicit redirect to cons_addr.
- States:
  - IDLE: ren=0. cons_ren or redirect -> RUN with fetch_addr = target.
  - RUN: ICACHE_ren=1, ICACHE_addr=fetch_addr while count + (pop?-1:0) < DEPTH. On ren & !stall: write {fetch_addr, rdata} at tail, fetch_addr+1 (mod 2^30). Full -> ren=0, stay RUN.
  - DRAIN: entered on redirect while ren=1 and stall=1. ren/addr held stable (cache protocol forbids abandoning a request); returned data discarded; on stall=0 -> RUN at pending redirect address.
- Redirect in RUN with no request pending or stall=0: queue cleared same edge, returned word (if any) discarded, fetch_addr=redirect_addr.
- Explicit redirect beats implicit redirect; redirect beats push and pop in the same cycle.
- Push and pop same cycle: count unchanged; allowed when full.
- Latency (feature off): miss -> word written on cache-accept edge, hit0 one cycle later.
- ICACHE_addr and ICACHE_ren must never change while ICACHE_stall=1 and ren=1.

Optional Feature:
PFQ_BYPASS_EN: when defined, if queue empty and the cache returns (ren & !stall) for ICACHE_addr==cons_addr with cons_ren=1, cons_rdata=ICACHE_rdata and cons_stall=0 in that same cycle; the word is still pushed. Without it, the word is visible only from the next cycle.

Test Plan:
- Reset, cons_ren=1, cons_addr=0x100, cache stall 2 cycles -> ICACHE_ren=1 addr 0x100; cons_stall=1 until cycle after accept; cons_rdata=cache word; prefetch continues 0x101..0x103, then ren=0 (DEPTH=4 full).
- Queue full {0x100..0x103}; consumer reads 0x100 twice then 0x101 -> no pop on repeats; pop on 0x101; next request issued for 0x104.
- redirect=1 addr 0x200 while cache stalled on 0x102 -> DRAIN holds addr 0x102 until stall=0, data discarded, next request 0x200, queue empty.
- Consumer jumps to 0x150 (not in queue) -> implicit flush, fetch restarts at 0x150, cons_stall=1 until word arrives.
- fetch_addr=0x3FFFFFFF accepted -> next request addr 0x00000000.
- PFQ_BYPASS_EN defined, empty queue, cache returns 0x300 data 0xDEADBEEF with cons_addr=0x300 -> cons_stall=0 and cons_rdata=0xDEADBEEF same cycle; undefined -> available next cycle.

Source files
------------

// File: rtl/inst_prefetch_queue_if.sv
// Purpose: bundles the realigner-facing and ICACHE-facing read buses of the prefetch queue.
// Latency: pure wiring, no storage.
// Backpressure: realigner side uses cons_stall, cache side uses ICACHE_stall.
// Signals:
//   cons_ren/cons_addr        realigner read request and word address
//   cons_rdata/cons_stall     word returned to the realigner, high stall = not valid
//   ICACHE_ren/ICACHE_addr    cache read request and word address
//   ICACHE_wen/ICACHE_wdata   write port, tied off by the queue
//   ICACHE_rdata/ICACHE_stall cache read data and busy flag
// Modports: master = prefetch queue, slave = environment (realigner + cache).
interface inst_prefetch_queue_if;
   logic        cons_ren;
   logic [29:0] cons_addr;
   logic [31:0] cons_rdata;
   logic        cons_stall;
   logic        ICACHE_ren;
   logic        ICACHE_wen;
   logic [29:0] ICACHE_addr;
   logic [31:0] ICACHE_wdata;
   logic [31:0] ICACHE_rdata;
   logic        ICACHE_stall;

   modport master (
      input  cons_ren, cons_addr, ICACHE_rdata, ICACHE_stall,
      output cons_rdata, cons_stall, ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
   );

   modport slave (
      output cons_ren, cons_addr, ICACHE_rdata, ICACHE_stall,
      input  cons_rdata, cons_stall, ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
   );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Purpose: instruction prefetch queue between ICACHE and the IF realigner, runs ahead sequentially.
// Latency: miss -> word written on cache-accept edge, readable next cycle (same cycle with bypass).
// Backpressure: stops requesting when DEPTH words are held; cons_stall while the word is absent.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   redirect, redirect_addr      flush and restart prefetch at a new word address
//   bus (master modport)         realigner lookup port and ICACHE read port
// Optional feature macro: PFQ_BYPASS_EN (serve an empty-queue miss straight from ICACHE_rdata).
module inst_prefetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect,
   input  logic [29:0]           redirect_addr,
   inst_prefetch_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [29:0]   fetch_addr_q, fetch_addr_d;
   logic [29:0]   pend_addr_q, pend_addr_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [29:0]   ent_addr_q [DEPTH];
   logic [29:0]   ent_addr_d [DEPTH];
   logic [31:0]   ent_data_q [DEPTH];
   logic [31:0]   ent_data_d [DEPTH];

   logic [PW-1:0] head1;
   logic [29:0]   target_addr;
   logic [29:0]   redir_tgt;
   logic [CW-1:0] count_after_pop;
   logic          hit0, hit1, bypass, outstanding;
   logic          implicit_redir, redir_any;
   logic          pop, push, accept, ren;

   // Consumer lookup and request generation.
   always_comb begin
      head1       = head_q + PW'(1);
      // While draining, the stream we are heading for is the pending redirect target.
      target_addr = (state_q == DRAIN) ? pend_addr_q : fetch_addr_q;

      hit0 = bus.cons_ren && (count_q != '0) && (ent_addr_q[head_q] == bus.cons_addr);
      hit1 = bus.cons_ren && !hit0 && (count_q >= CW'(2)) &&
             (ent_addr_q[head1] == bus.cons_addr);

      // With fewer than two words held, the next word to be fetched will land in
      // entry0 or entry1, so asking for it is not a change of stream.
      outstanding    = (count_q <= CW'(1)) && (bus.cons_addr == target_addr);
      implicit_redir = bus.cons_ren && (state_q != IDLE) && !hit0 && !hit1 && !outstanding;
      redir_any      = redirect || implicit_redir;
      redir_tgt      = redirect ? redirect_addr : bus.cons_addr;

      pop             = hit1 && !redir_any;
      count_after_pop = count_q - CW'(pop);

      // Once a request is stalled, count cannot grow until it is accepted, so ren
      // and fetch_addr stay put for the whole stall.
      ren    = (state_q == DRAIN) || ((state_q == RUN) && (count_after_pop < FULL_CNT));
      accept = ren && !bus.ICACHE_stall;
      push   = accept && (state_q == RUN) && !redir_any;

`ifdef PFQ_BYPASS_EN
      bypass = bus.cons_ren && (count_q == '0) && push && (fetch_addr_q == bus.cons_addr);
`else
      bypass = 1'b0;
`endif
   end

   assign bus.ICACHE_ren   = ren;
   assign bus.ICACHE_addr  = fetch_addr_q;
   assign bus.ICACHE_wen   = 1'b0;
   assign bus.ICACHE_wdata = '0;
   assign bus.cons_stall   = bus.cons_ren && !(hit0 || hit1 || bypass);
   assign bus.cons_rdata   = bypass ? bus.ICACHE_rdata :
                             hit1   ? ent_data_q[head1] : ent_data_q[head_q];

   // Next-state logic for the controller and the queue.
   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      pend_addr_d  = pend_addr_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      ent_addr_d   = ent_addr_q;
      ent_data_d   = ent_data_q;

      case (state_q)
         IDLE: begin
            if (redirect || bus.cons_ren) begin
               state_d      = RUN;
               fetch_addr_d = redir_tgt;
            end
         end
         RUN: begin
            if (redir_any) begin
               // Flush wins over push/pop; any word returned this cycle is dropped.
               head_d  = '0;
               tail_d  = '0;
               count_d = '0;
               if (ren && bus.ICACHE_stall) begin
                  // A stalled request cannot be withdrawn: ride it out in DRAIN.
                  state_d     = DRAIN;
                  pend_addr_d = redir_tgt;
               end else begin
                  fetch_addr_d = redir_tgt;
               end
            end else begin
               if (push) begin
                  ent_addr_d[tail_q] = fetch_addr_q;
                  ent_data_d[tail_q] = bus.ICACHE_rdata;
                  tail_d             = tail_q + PW'(1);
                  fetch_addr_d       = fetch_addr_q + 30'd1;
               end
               if (pop) begin
                  head_d = head1;
               end
               count_d = count_q + CW'(push) - CW'(pop);
            end
         end
         DRAIN: begin
            if (redir_any) begin
               pend_addr_d = redir_tgt;
            end
            if (!bus.ICACHE_stall) begin
               state_d      = RUN;
               fetch_addr_d = redir_any ? redir_tgt : pend_addr_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fetch_addr_q <= '0;
         pend_addr_q  <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         pend_addr_q  <= pend_addr_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         ent_addr_q   <= ent_addr_d;
         ent_data_q   <= ent_data_d;
      end
   end
endmodule
